muldiv_sequencer: RTL and testbench

//  Multi-cycle sequencer for the ALU_MULT / ALU_DIV operations emitted by ALU control.

---
 rtl/muldiv_sequencer_pkg.sv | 21 ++
 rtl/muldiv_sequencer_if.sv | 27 ++
 rtl/muldiv_step.sv | 25 ++
 rtl/muldiv_sequencer.sv | 122 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared op codes and widths for the multiply/divide sequencer and its bus.
package muldiv_sequencer_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int OP_SIZE        = 6;

   localparam logic [OP_SIZE-1:0] ALU_MFHI = 6'd16;
   localparam logic [OP_SIZE-1:0] ALU_MFLO = 6'd18;
   localparam logic [OP_SIZE-1:0] ALU_MULT = 6'd24;
   localparam logic [OP_SIZE-1:0] ALU_DIV  = 6'd26;

   function automatic logic is_muldiv_op(input logic [OP_SIZE-1:0] op);
      return (op == ALU_MULT) || (op == ALU_DIV);
   endfunction

   // Any op that depends on HI/LO must wait until the sequencer is idle.
   function automatic logic is_hilo_op(input logic [OP_SIZE-1:0] op);
      return is_muldiv_op(op) || (op == ALU_MFHI) || (op == ALU_MFLO);
   endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Issue/result bus between ALU control and the multiply/divide sequencer.
interface muldiv_sequencer_if
   import muldiv_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic                  start;
   logic [OP_SIZE-1:0]    operation;
   logic [DATA_WIDTH-1:0] operand_a;
   logic [DATA_WIDTH-1:0] operand_b;
   logic                  busy;
   logic                  done;
   logic                  stall;
   logic                  div_zero;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;

   modport master (
      output start, operation, operand_a, operand_b,
      input  busy, done, stall, div_zero, hi, lo
   );

   modport slave (
      input  start, operation, operand_a, operand_b,
      output busy, done, stall, div_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on a 2W accumulator.
module muldiv_step #(
   parameter int W = 32
) (
   input  logic           op_div_i,
   input  logic [2*W-1:0] acc_i,
   input  logic [W-1:0]   opnd_i,
   output logic [2*W-1:0] acc_o
);
   logic [W:0]     sum;
   logic [2*W-1:0] sh;
   logic [W:0]     trial;

   always_comb begin
      sum   = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, opnd_i} : {(W+1){1'b0}});
      sh    = {acc_i[2*W-2:0], 1'b0};
      // Remainder stays below the divisor magnitude, so the shifted value fits in W bits.
      trial = {1'b0, sh[2*W-1:W]} - {1'b0, opnd_i};
      if (op_div_i) begin
         acc_o = trial[W] ? sh : {trial[W-1:0], acc_i[W-2:0], 1'b1};
      end else begin
         acc_o = {sum, acc_i[W-1:1]};
      end
   end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT/DIV sequencer owning HI/LO; one bit per cycle, stalls HI/LO users while busy.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                clk,
   input  logic                reset,
   muldiv_sequencer_if.slave   mdu
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   state_e           state_q;
   logic [CW-1:0]    count_q;
   logic [2*W-1:0]   acc_q;
   logic [2*W-1:0]   acc_d;
   logic [W-1:0]     opnd_q;
   logic             sign_a_q;
   logic             sign_b_q;
   logic             op_div_q;
   logic             dz_pend_q;
   logic             done_q;
   logic             div_zero_q;
   logic [W-1:0]     hi_q;
   logic [W-1:0]     lo_q;

   logic             accept;
   logic             is_div;
   logic             b_zero;
   logic [W-1:0]     a_mag;
   logic [W-1:0]     b_mag;
   logic [2*W-1:0]   prod_neg;
   logic [W-1:0]     quo_neg;
   logic [W-1:0]     rem_neg;

   assign accept   = mdu.start && (state_q == S_IDLE) && is_muldiv_op(mdu.operation);
   assign is_div   = (mdu.operation == ALU_DIV);
   assign b_zero   = (mdu.operand_b == '0);
   assign a_mag    = mdu.operand_a[W-1] ? -mdu.operand_a : mdu.operand_a;
   assign b_mag    = mdu.operand_b[W-1] ? -mdu.operand_b : mdu.operand_b;
   assign prod_neg = -acc_q;
   assign quo_neg  = -acc_q[W-1:0];
   assign rem_neg  = -acc_q[2*W-1:W];

   muldiv_step #(.W(W)) u_step (
      .op_div_i (op_div_q),
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .acc_o    (acc_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         op_div_q   <= 1'b0;
         dz_pend_q  <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  sign_a_q   <= mdu.operand_a[W-1];
                  sign_b_q   <= mdu.operand_b[W-1];
                  op_div_q   <= is_div;
                  acc_q      <= {{W{1'b0}}, a_mag};
                  opnd_q     <= b_mag;
                  count_q    <= '0;
                  div_zero_q <= 1'b0;
                  dz_pend_q  <= is_div && b_zero;
                  state_q    <= (is_div && b_zero) ? S_FIX : S_CALC;
               end
            end
            S_CALC: begin
               acc_q   <= acc_d;
               count_q <= count_q + 1'b1;
               if (count_q == CW'(W - 1)) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               done_q  <= 1'b1;
               state_q <= S_IDLE;
               if (dz_pend_q) begin
                  // acc low half still holds |a|; rebuild the signed dividend for HI.
                  hi_q       <= sign_a_q ? quo_neg : acc_q[W-1:0];
                  lo_q       <= '1;
                  div_zero_q <= 1'b1;
               end else if (op_div_q) begin
                  lo_q <= (sign_a_q ^ sign_b_q) ? quo_neg : acc_q[W-1:0];
                  hi_q <= sign_a_q ? rem_neg : acc_q[2*W-1:W];
               end else begin
                  {hi_q, lo_q} <= (sign_a_q ^ sign_b_q) ? prod_neg : acc_q;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mdu.busy     = (state_q != S_IDLE);
   assign mdu.done     = done_q;
   assign mdu.stall    = mdu.start && (state_q != S_IDLE) && is_hilo_op(mdu.operation);
   assign mdu.div_zero = div_zero_q;
   assign mdu.hi       = hi_q;
   assign mdu.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench: signed 64-bit reference model feeds a scoreboard checked at each done pulse.
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;

   typedef struct {
      string       tag;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   muldiv_sequencer_if #(.DATA_WIDTH(32)) mdu ();

   muldiv_sequencer #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (mdu)
   );

   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   int   acc_cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [OP_SIZE-1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input string tag);
      exp_t e;
      longint a64, b64, p, q, r;
      a64 = longint'(signed'(a));
      b64 = longint'(signed'(b));
      e.tag = tag;
      e.dz  = 1'b0;
      e.lat = 33;
      if (op == ALU_MULT) begin
         p    = a64 * b64;
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (b == 32'd0) begin
         e.hi  = a;
         e.lo  = 32'hFFFF_FFFF;
         e.dz  = 1'b1;
         e.lat = 1;
      end else begin
         q    = a64 / b64;
         r    = a64 % b64;
         e.lo = q[31:0];
         e.hi = r[31:0];
      end
      return e;
   endfunction

   task automatic issue(input logic [OP_SIZE-1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
      @(negedge clk);
      mdu.start     = 1'b1;
      mdu.operation = op;
      mdu.operand_a = a;
      mdu.operand_b = b;
      sb_q.push_back(model(op, a, b, tag));
      @(negedge clk);
      mdu.start     = 1'b0;
      mdu.operation = '0;
      acc_cyc       = cyc;
   endtask

   task automatic wait_done();
      exp_t e;
      int   n = 0;
      while (mdu.done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() == 0) begin
         check("scoreboard empty", 64'd1, 64'd0);
         return;
      end
      e = sb_q.pop_front();
      check({e.tag, " latency"}, 64'(cyc - acc_cyc), 64'(e.lat));
      check({e.tag, " hi"}, 64'(mdu.hi), 64'(e.hi));
      check({e.tag, " lo"}, 64'(mdu.lo), 64'(e.lo));
      check({e.tag, " div_zero"}, 64'(mdu.div_zero), 64'(e.dz));
      check({e.tag, " busy at done"}, 64'(mdu.busy), 64'd0);
      @(negedge clk);
      check({e.tag, " done pulse"}, 64'(mdu.done), 64'd0);
   endtask

   initial begin : stim
      logic [31:0] saved_hi;
      logic        seen_done;
      reset         = 1'b1;
      mdu.start     = 1'b0;
      mdu.operation = '0;
      mdu.operand_a = '0;
      mdu.operand_b = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 64'(mdu.busy), 64'd0);
      check("reset done", 64'(mdu.done), 64'd0);
      check("reset div_zero", 64'(mdu.div_zero), 64'd0);
      check("reset hi/lo", {mdu.hi, mdu.lo}, 64'd0);
      reset = 1'b0;

      issue(ALU_MULT, 32'd7, -32'sd3, "mult 7*-3");
      wait_done();
      check("mult 7*-3 hi const", 64'(mdu.hi), 64'hFFFF_FFFF);
      check("mult 7*-3 lo const", 64'(mdu.lo), 64'hFFFF_FFEB);

      issue(ALU_MULT, 32'h8000_0000, 32'h8000_0000, "mult minint^2");
      wait_done();
      check("mult minint^2 hi const", 64'(mdu.hi), 64'h4000_0000);

      issue(ALU_DIV, -32'sd7, 32'd2, "div -7/2");
      wait_done();
      issue(ALU_DIV, 32'd100, 32'd7, "div 100/7");
      wait_done();
      check("div 100/7 const", {mdu.hi, mdu.lo}, {32'd2, 32'd14});

      issue(ALU_DIV, 32'd5, 32'd0, "div 5/0");
      wait_done();
      issue(ALU_MULT, 32'd3, 32'd4, "mult 3*4");
      check("div_zero cleared on accept", 64'(mdu.div_zero), 64'd0);
      wait_done();

      // Hazards while busy: neither MFHI nor a new DIV may disturb the running MULT.
      issue(ALU_MULT, 32'd12345, -32'sd678, "mult under stall");
      repeat (5) @(negedge clk);
      saved_hi      = mdu.hi;
      mdu.start     = 1'b1;
      mdu.operation = ALU_MFHI;
      #1;
      check("stall on MFHI busy", 64'(mdu.stall), 64'd1);
      @(negedge clk);
      check("hi held while busy", 64'(mdu.hi), 64'(saved_hi));
      mdu.operation = ALU_DIV;
      mdu.operand_a = 32'd9;
      mdu.operand_b = 32'd0;
      #1;
      check("stall on DIV busy", 64'(mdu.stall), 64'd1);
      @(negedge clk);
      mdu.start     = 1'b0;
      mdu.operation = '0;
      check("busy after ignored DIV", 64'(mdu.busy), 64'd1);
      wait_done();
      @(negedge clk);
      mdu.start     = 1'b1;
      mdu.operation = ALU_MFHI;
      #1;
      check("no stall MFHI idle", 64'(mdu.stall), 64'd0);
      @(negedge clk);
      mdu.start     = 1'b0;
      mdu.operation = '0;

      issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div minint/-1");
      wait_done();
      issue(ALU_DIV, 32'h8000_0000, 32'd0, "div minint/0");
      wait_done();
      issue(ALU_DIV, 32'd3, -32'sd10, "div 3/-10");
      wait_done();

      for (int i = 0; i < 4; i++) begin
         issue((i % 2 == 0) ? ALU_MULT : ALU_DIV, $urandom, $urandom_range(1, 32'h7FFF_FFFF)
               * (($urandom_range(0, 1) == 1) ? 32'd1 : 32'hFFFF_FFFF), $sformatf("rand %0d", i));
         wait_done();
      end

      issue(ALU_MULT, 32'd7, -32'sd3, "mult aborted");
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort busy", 64'(mdu.busy), 64'd0);
      check("abort done", 64'(mdu.done), 64'd0);
      check("abort hi/lo", {mdu.hi, mdu.lo}, 64'd0);
      void'(sb_q.pop_back());
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (mdu.done === 1'b1) seen_done = 1'b1;
      end
      check("no done after abort", 64'(seen_done), 64'd0);
      check("scoreboard drained", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
